// File: rtl/rc2014_bus_master.sv
// rc2014_bus_master: bus initiator for the RC2014 backplane.
// Requests the bus from the Z80 via BUSRQ/BUSAK, then runs Z80-style memory
// and IO read/write cycles (T1, T2, TW..., T3) for an internal command port.
// Keeps the bus between commands and hands it back after an idle period.
module rc2014_bus_master #(
  parameter int WAIT_STATES  = 0,
  parameter int WAIT_TIMEOUT = 255,
  parameter int RELEASE_IDLE = 15
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic        cmd_io,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_timeout,
  output logic [15:0] A,
  output logic [7:0]  D_OUT,
  input  logic [7:0]  D_IN,
  output logic        DATA_DIR,
  output logic        ADDR_DIR,
  output logic        MRQ,
  output logic        IORQ,
  output logic        RD,
  output logic        WR,
  output logic        M1,
  output logic        BUSRQ,
  input  logic        BUSAK,
  input  logic        WAIT
);

  localparam logic [8:0]  FIXED_WAITS = 9'(WAIT_STATES);
  localparam logic [8:0]  TIMEOUT_LIM = 9'(WAIT_TIMEOUT);
  localparam logic [16:0] RELEASE_LIM = 17'(RELEASE_IDLE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_T1,
    S_T2,
    S_TW,
    S_T3,
    S_OWN
  } state_t;

  state_t      state, next_state;
  logic        busak_s1, busak_s2, wait_s1, wait_s2;
  logic        lat_write, lat_io;
  logic [15:0] lat_addr;
  logic [7:0]  lat_wdata;
  logic [7:0]  tw_cnt, tw_cnt_next;
  logic [15:0] idle_cnt, idle_cnt_next;
  logic        abort, abort_next;
  logic        accept;
  logic        cur_write, cur_io;
  logic [15:0] cur_addr;
  logic [7:0]  cur_wdata;
  logic [8:0]  waits_due, tw_done;
  logic        strobe_on, data_phase, bus_drive;

  // A command arriving with the accepting edge is used directly for the T1
  // that follows it; later phases use the latched copy.
  assign accept    = cmd_valid && cmd_ready;
  assign cur_write = accept ? cmd_write : lat_write;
  assign cur_io    = accept ? cmd_io    : lat_io;
  assign cur_addr  = accept ? cmd_addr  : lat_addr;
  assign cur_wdata = accept ? cmd_wdata : lat_wdata;
  assign waits_due = FIXED_WAITS + {8'd0, lat_io};
  assign tw_done   = {1'b0, tw_cnt} + 9'd1;
  assign M1        = 1'b1;

  assign strobe_on  = (next_state == S_T2) || (next_state == S_TW) || (next_state == S_T3);
  assign data_phase = strobe_on || (next_state == S_T1);
  assign bus_drive  = data_phase || (next_state == S_OWN);

  // Two-flop synchronisers for the asynchronous BUSAK and WAIT inputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      busak_s1 <= 1'b1;
      busak_s2 <= 1'b1;
      wait_s1  <= 1'b1;
      wait_s2  <= 1'b1;
    end else begin
      busak_s1 <= BUSAK;
      busak_s2 <= busak_s1;
      wait_s1  <= WAIT;
      wait_s2  <= wait_s1;
    end
  end

  // Capture the command on acceptance so it survives the whole bus cycle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      lat_write <= 1'b0;
      lat_io    <= 1'b0;
      lat_addr  <= 16'h0000;
      lat_wdata <= 8'h00;
    end else if (accept) begin
      lat_write <= cmd_write;
      lat_io    <= cmd_io;
      lat_addr  <= cmd_addr;
      lat_wdata <= cmd_wdata;
    end
  end

  // State register plus the wait-state, idle and abort bookkeeping.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= S_IDLE;
      tw_cnt   <= 8'd0;
      idle_cnt <= 16'd0;
      abort    <= 1'b0;
    end else begin
      state    <= next_state;
      tw_cnt   <= tw_cnt_next;
      idle_cnt <= idle_cnt_next;
      abort    <= abort_next;
    end
  end

  // Next-state logic: TW holds for the fixed waits, then while WAIT is low,
  // and is forced on to T3 with the abort flag once the timeout is reached.
  always_comb begin
    next_state    = state;
    tw_cnt_next   = tw_cnt;
    idle_cnt_next = idle_cnt;
    abort_next    = abort;
    case (state)
      S_IDLE: begin
        if (accept) begin
          next_state = S_REQ;
          abort_next = 1'b0;
        end
      end
      S_REQ: begin
        if (!busak_s2) next_state = S_T1;
      end
      S_T1: begin
        next_state  = S_T2;
        tw_cnt_next = 8'd0;
      end
      S_T2: begin
        if ((waits_due != 9'd0) || !wait_s2) next_state = S_TW;
        else                                 next_state = S_T3;
      end
      S_TW: begin
        tw_cnt_next = (tw_cnt == 8'hFF) ? tw_cnt : tw_cnt + 8'd1;
        if ((tw_done < waits_due) || !wait_s2) begin
          if (tw_done >= TIMEOUT_LIM) begin
            next_state = S_T3;
            abort_next = 1'b1;
          end
        end else begin
          next_state = S_T3;
        end
      end
      S_T3: begin
        next_state    = S_OWN;
        idle_cnt_next = 16'd0;
      end
      S_OWN: begin
        if (accept) begin
          next_state    = S_T1;
          idle_cnt_next = 16'd0;
          abort_next    = 1'b0;
        end else if (({1'b0, idle_cnt} + 17'd1) >= RELEASE_LIM) begin
          next_state = S_IDLE;
        end else begin
          idle_cnt_next = (idle_cnt == 16'hFFFF) ? idle_cnt : idle_cnt + 16'd1;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Registered bus and response outputs, decoded from the state being entered.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cmd_ready   <= 1'b1;
      BUSRQ       <= 1'b1;
      ADDR_DIR    <= 1'b0;
      DATA_DIR    <= 1'b0;
      MRQ         <= 1'b1;
      IORQ        <= 1'b1;
      RD          <= 1'b1;
      WR          <= 1'b1;
      A           <= 16'h0000;
      D_OUT       <= 8'h00;
      rsp_valid   <= 1'b0;
      rsp_timeout <= 1'b0;
      rsp_rdata   <= 8'hFF;
    end else begin
      cmd_ready   <= (next_state == S_IDLE) || (next_state == S_OWN);
      BUSRQ       <= (next_state == S_IDLE);
      ADDR_DIR    <= bus_drive;
      DATA_DIR    <= data_phase && cur_write;
      MRQ         <= !(strobe_on && !cur_io);
      IORQ        <= !(strobe_on && cur_io);
      RD          <= !(strobe_on && !cur_write);
      WR          <= !(strobe_on && cur_write);
      rsp_valid   <= (state == S_T3);
      rsp_timeout <= (state == S_T3) && abort;
      if (next_state == S_T1) begin
        A     <= cur_addr;
        D_OUT <= cur_wdata;
      end
      if (state == S_T3) begin
        rsp_rdata <= (!lat_write && !abort) ? D_IN : 8'hFF;
      end
    end
  end

endmodule
